led_ctl: RTL and testbench
==========================

# led_ctl

LED pattern generator that consumes the 2-bit mode code produced by the key-press counter and drives the board LED bank. It registers the mode, restarts its pattern cleanly on every mode change, and produces off, blink, running-light and (optionally) breathing patterns from a shared tick prescaler. It sits between the key control logic and the LED pins in the 27 MHz clock domain.

## Interface
- `LED_WIDTH`, 4, number of LEDs driven; must be ≥ 2.
- `TICK_CNT`, 13_500_000, clock cycles per pattern step (0.5 s at 27 MHz); must be ≥ 2.
- `BREATH_STEP`, 52_734, clock cycles per duty step in breathing mode.

Ports:
- `clk`  in  1  system clock, 27 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ctrl`  in  2  mode code: 0 off, 1 blink, 2 running light, 3 breathing. Synchronous to `clk`.
- `led`  out  `LED_WIDTH`  registered LED drive, active-high, where 1 means the LED is on.

## Operation
- **Mode register**
  - `mode_q` holds the current mode.
  - A mode change occurs when `ctrl != mode_q`.
  - On a mode change, the next edge loads `mode_q <= ctrl`, clears `tick_cnt` and reloads the pattern state for the new mode.
  - The mode-change reload has priority over any tick in the same cycle.
- **Prescaler**
  - `tick_cnt` is `$clog2(TICK_CNT)` bits wide and counts 0 to `TICK_CNT-1`, then wraps to 0.
  - `tick` is high for the cycle in which `tick_cnt == TICK_CNT-1`.
- **Mode 0 (off)**
  - `led = 0`.
- **Mode 1 (blink)**
  - Entry sets `blink_q = 1`.
  - `blink_q` toggles on each tick.
  - `led = {LED_WIDTH{blink_q}}`.
- **Mode 2 (running light)**
  - Entry sets `flow_q` to one-hot bit 0.
  - On each tick, `flow_q` rotates left; bit `LED_WIDTH-1` wraps to bit 0.
  - `led = flow_q`.
- **Mode 3** is defined under Configuration.
- **Reset values**
  - `mode_q = 0`, `tick_cnt = 0`, `blink_q = 0`, `flow_q = 1`.
  - Breathing state: `duty = 0`, `dir = up`, `pwm_cnt = 0`, `step_cnt = 0`.
  - `led = 0`.
- **Reset mid-operation**
  - `led` goes to 0 asynchronously, without waiting for a clock edge.
  - After release, a nonzero `ctrl` is seen as a mode change on the first edge and the pattern restarts from entry.

## Timing
- `ctrl` changes before edge k. At edge k, `mode_q`, `tick_cnt` and the pattern state update. At edge k+1, `led` shows the entry pattern. Latency is 2 edges.
- The first pattern step appears at edge k+1+`TICK_CNT`. After that, one step occurs every `TICK_CNT` cycles.
- `ctrl` is not debounced or synchronized here; its source is a synchronous register in the `clk` domain.
- A `ctrl` glitch lasting one cycle still restarts the pattern twice. This is accepted behaviour.

## Configuration
- The macro `LED_BREATH_EN` controls mode 3.
- **With `LED_BREATH_EN` defined**, mode 3 breathes:
  - `pwm_cnt` is 8 bits and free-running.
  - `led` bits are all `(pwm_cnt < duty)`.
  - `step_cnt` is a modulo-`BREATH_STEP` counter. Its wrap adjusts `duty` by ±1 according to `dir`.
  - At `duty == 255`, `dir` switches to down. At `duty == 0`, `dir` switches to up. The switch occurs in the same cycle as the step that reaches the endpoint.
  - Entry resets `duty`, `dir`, `pwm_cnt` and `step_cnt` to their reset values.
- **Without `LED_BREATH_EN`**, mode 3 behaves exactly like mode 0 (`led = 0`), and no breathing registers or `BREATH_STEP` logic are synthesized.

## Test plan
All scenarios use `TICK_CNT=4`, `LED_WIDTH=4`, and `BREATH_STEP=1` unless noted otherwise.
- **Reset:** assert `rst_n=0` mid-cycle. Required: `led=4'h0` immediately. Release with `ctrl=0`: `led` stays `4'h0` for 20 cycles.
- **Blink:** set `ctrl=1` before edge k. Required:
  - `led=4'hF` from k+1.
  - `led=4'h0` from k+5.
  - `led=4'hF` from k+9, and the toggle continues every 4 cycles.
- **Running light:** set `ctrl=2` before edge k. Required: `led` is `0001` at k+1, `0010` at k+5, `0100` at k+9, `1000` at k+13, and wraps to `0001` at k+17.
- **Mode change mid-period:** in mode 2 with `led=0100` and two cycles into the period, set `ctrl=1`. Required: `led=4'hF` two edges later, then `4'h0` exactly 4 cycles after that (prescaler restarted).
- **Mode 3:**
  - Without the macro: `led=4'h0` for 600 cycles.
  - With `LED_BREATH_EN`: `duty` reaches 255 after 255 cycles, then decrements. The count of `led=4'hF` cycles in any 256-cycle `pwm_cnt` window equals `duty` sampled at window start, within ±1.
- **Reset mid-blink:** pulse `rst_n` low while `led=4'h0` with `ctrl=1` held. Required: `led=4'h0` during reset, then `4'hF` two edges after release, with a full 4-cycle period before the next toggle.

Source files
------------

// File: rtl/led_ctl.sv
// led_ctl: LED pattern generator for the board LED bank.
//
// Registers the 2-bit mode code from the key-press counter and drives the LEDs
// with one of four patterns. Every mode change restarts the selected pattern
// and the tick prescaler, so each pattern begins with its entry state and a
// full step period.
//
//   mode 0  off            all LEDs dark
//   mode 1  blink          all LEDs toggle together once per tick
//   mode 2  running light  single lit LED rotating left once per tick
//   mode 3  breathing      8-bit PWM whose duty ramps 0..255..0
//                          (only with LED_BREATH_EN; otherwise same as mode 0)
//
// Build option:
//   LED_BREATH_EN  define to build the breathing pattern for mode 3. When it is
//                  undefined, no breathing registers are built.
//
// Parameters:
//   LED_WIDTH    number of LEDs driven (>= 2)
//   TICK_CNT     clock cycles per pattern step (>= 2)
//   BREATH_STEP  clock cycles per duty step in breathing mode (>= 1)
//
// Ports:
//   clk    in   system clock (27 MHz)
//   rst_n  in   asynchronous active-low reset
//   ctrl   in   mode code, synchronous to clk (no synchroniser here)
//   led    out  registered LED drive, active-high (1 = LED on)

module led_ctl #(
  parameter int unsigned LED_WIDTH   = 4,
  parameter int unsigned TICK_CNT    = 13_500_000,
  parameter int unsigned BREATH_STEP = 52_734
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           ctrl,
  output logic [LED_WIDTH-1:0] led
);

  // Elaboration-time parameter sanity check.
  if (LED_WIDTH < 2 || TICK_CNT < 2 || BREATH_STEP < 1) begin : g_param_err
    $error("led_ctl: LED_WIDTH and TICK_CNT must be >= 2, BREATH_STEP >= 1");
  end

  localparam int unsigned TickW = $clog2(TICK_CNT);
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_CNT - 1);

  typedef enum logic [1:0] {
    ModeOff    = 2'd0,
    ModeBlink  = 2'd1,
    ModeFlow   = 2'd2,
    ModeBreath = 2'd3
  } mode_e;

  mode_e                mode_q, mode_d;
  logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
  logic                 blink_q, blink_d;
  logic [LED_WIDTH-1:0] flow_q, flow_d;
  logic [LED_WIDTH-1:0] led_q, led_d;

  logic mode_chg;
  logic tick;

  assign mode_chg = (ctrl != mode_q);
  assign tick     = (tick_cnt_q == TickMax);

  // ---------------------------------------------------------------------------
  // Mode register and prescaler
  // ---------------------------------------------------------------------------
  always_comb begin
    mode_d     = mode_q;
    tick_cnt_d = tick_cnt_q + TickW'(1);
    if (mode_chg) begin
      // Restart the step period so the new pattern gets a full first step.
      mode_d     = mode_e'(ctrl);
      tick_cnt_d = '0;
    end else if (tick) begin
      tick_cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Blink and running-light state
  // ---------------------------------------------------------------------------
  // Both patterns are reloaded on any mode change; the state of an inactive
  // pattern is never shown, so this keeps the entry logic to a single branch.
  always_comb begin
    blink_d = blink_q;
    flow_d  = flow_q;
    if (mode_chg) begin
      blink_d = 1'b1;
      flow_d  = LED_WIDTH'(1);
    end else if (tick) begin
      if (mode_q == ModeBlink) begin
        blink_d = ~blink_q;
      end
      if (mode_q == ModeFlow) begin
        flow_d = {flow_q[LED_WIDTH-2:0], flow_q[LED_WIDTH-1]};
      end
    end
  end

`ifdef LED_BREATH_EN
  // ---------------------------------------------------------------------------
  // Breathing state
  // ---------------------------------------------------------------------------
  localparam int unsigned StepW = (BREATH_STEP > 1) ? $clog2(BREATH_STEP) : 1;
  localparam logic [StepW-1:0] StepMax = StepW'(BREATH_STEP - 1);

  logic [7:0]       pwm_cnt_q, pwm_cnt_d;
  logic [7:0]       duty_q, duty_d;
  logic             dir_down_q, dir_down_d;
  logic [StepW-1:0] step_cnt_q, step_cnt_d;
  logic             step_wrap;
  logic             breath_on;

  assign step_wrap = (step_cnt_q == StepMax);
  assign breath_on = (pwm_cnt_q < duty_q);

  always_comb begin
    pwm_cnt_d  = pwm_cnt_q;
    duty_d     = duty_q;
    dir_down_d = dir_down_q;
    step_cnt_d = step_cnt_q;
    if (mode_chg) begin
      pwm_cnt_d  = '0;
      duty_d     = '0;
      dir_down_d = 1'b0;
      step_cnt_d = '0;
    end else if (mode_q == ModeBreath) begin
      pwm_cnt_d  = pwm_cnt_q + 8'd1;
      step_cnt_d = step_wrap ? '0 : step_cnt_q + StepW'(1);
      if (step_wrap) begin
        // Direction flips on the same step that lands on an endpoint.
        if (!dir_down_q) begin
          duty_d = duty_q + 8'd1;
          if (duty_q == 8'd254) begin
            dir_down_d = 1'b1;
          end
        end else begin
          duty_d = duty_q - 8'd1;
          if (duty_q == 8'd1) begin
            dir_down_d = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q  <= '0;
      duty_q     <= '0;
      dir_down_q <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      duty_q     <= duty_d;
      dir_down_q <= dir_down_d;
      step_cnt_q <= step_cnt_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // LED output
  // ---------------------------------------------------------------------------
  // Decoded from the registered mode and pattern state, then registered again,
  // so a new pattern is visible one edge after the mode register updates.
  always_comb begin
    led_d = '0;
    unique case (mode_q)
      ModeOff:   led_d = '0;
      ModeBlink: led_d = {LED_WIDTH{blink_q}};
      ModeFlow:  led_d = flow_q;
      ModeBreath: begin
`ifdef LED_BREATH_EN
        led_d = {LED_WIDTH{breath_on}};
`else
        led_d = '0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= ModeOff;
      tick_cnt_q <= '0;
      blink_q    <= 1'b0;
      flow_q     <= LED_WIDTH'(1);
      led_q      <= '0;
    end else begin
      mode_q     <= mode_d;
      tick_cnt_q <= tick_cnt_d;
      blink_q    <= blink_d;
      flow_q     <= flow_d;
      led_q      <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_ctl.sv
// Testbench for led_ctl with LED_WIDTH=4, TICK_CNT=4, BREATH_STEP=1.
// Expected LED values are queued with the cycle at which they must appear and
// compared by a monitor on the falling clock edge.

module tb_led_ctl;

  localparam int unsigned W  = 4;
  localparam int unsigned TC = 4;
  localparam int unsigned BS = 1;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [1:0]   ctrl  = 2'd0;
  logic [W-1:0] led;

  always #5 clk = ~clk;

  led_ctl #(
    .LED_WIDTH  (W),
    .TICK_CNT   (TC),
    .BREATH_STEP(BS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ctrl (ctrl),
    .led  (led)
  );

  // Number of rising edges seen so far; edge k is the one that makes cyc == k.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int unsigned at;
    logic [W-1:0] val;
    string        tag;
  } exp_t;

  exp_t sb_q[$];

  task automatic push(input int unsigned at, input logic [W-1:0] val, input string tag);
    exp_t e;
    e.at  = at;
    e.val = val;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Monitor: compare every queued expectation whose cycle has come.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.at == cyc) check(e.tag, 32'(led), 32'(e.val));
      else             check("sb_order", cyc, e.at);
    end
  end

  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

`ifdef LED_BREATH_EN
  // Duty after n steps from entry: triangle 0..255..0 with period 510.
  function automatic int unsigned duty_at(input int unsigned n);
    int unsigned p;
    p = n % 510;
    return (p <= 255) ? p : 510 - p;
  endfunction
`endif

  initial begin
    int unsigned k;
    int unsigned k2;
    int unsigned r;

    // Asynchronous reset mid-cycle, before any clock edge.
    #3 rst_n = 1'b0;
    #1 check("rst_async", 32'(led), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    k = cyc;
    for (int unsigned c = k + 1; c <= k + 20; c++) push(c, 4'h0, "reset_idle");
    wait_until(k + 20);

    // Blink: F from k+1, toggling every 4 cycles.
    k = cyc + 1;
    ctrl = 2'd1;
    for (int unsigned c = k + 1; c <= k + 16; c++)
      push(c, (((c - k - 1) / TC) % 2 == 0) ? 4'hF : 4'h0, "blink");
    wait_until(k + 16);

    // Running light, through a wrap and into the third step of the next lap.
    k = cyc + 1;
    ctrl = 2'd2;
    for (int unsigned c = k + 1; c <= k + 26; c++)
      push(c, 4'(1 << (((c - k - 1) / TC) % W)), "flow");
    wait_until(k + 26);

    // Two cycles into the 0100 step, switch to blink.
    ctrl = 2'd1;
    k2 = k + 27;
    push(k2, 4'b0100, "chg_hold");
    for (int unsigned c = k2 + 1; c <= k2 + 8; c++)
      push(c, (c <= k2 + TC) ? 4'hF : 4'h0, "chg_blink");
    wait_until(k2 + 8);

    // Mode 3.
    k = cyc + 1;
    ctrl = 2'd3;
`ifdef LED_BREATH_EN
    begin
      int unsigned cnt [2];
      int unsigned exp_cnt [2];
      cnt     = '{0, 0};
      exp_cnt = '{0, 0};
      for (int unsigned n = 0; n < 512; n++) begin
        wait_until(k + 1 + n);
        if (led == 4'hF) cnt[n / 256]++;
        else if (led != 4'h0) check("breath_level", 32'(led), 32'h0);
        if ((n % 256) < duty_at(n)) exp_cnt[n / 256]++;
      end
      for (int w = 0; w < 2; w++) begin
        check("breath_win", 32'((cnt[w] + 1 >= exp_cnt[w]) && (cnt[w] <= exp_cnt[w] + 1)), 32'h1);
      end
    end
`else
    for (int unsigned c = k + 1; c <= k + 600; c++) push(c, 4'h0, "mode3_off");
    wait_until(k + 600);
`endif

    // Reset in the dark half of a blink period, ctrl=1 held.
    k = cyc + 1;
    ctrl = 2'd1;
    for (int unsigned c = k + 1; c <= k + 6; c++)
      push(c, (c <= k + TC) ? 4'hF : 4'h0, "pre_rst_blink");
    wait_until(k + 6);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_async", 32'(led), 32'h0);
    @(negedge clk);
    check("rst_hold", 32'(led), 32'h0);
    r = cyc;
    rst_n = 1'b1;
    push(r + 1, 4'h0, "post_rst_wait");
    for (int unsigned c = r + 2; c <= r + 9; c++)
      push(c, (c <= r + 1 + TC) ? 4'hF : 4'h0, "post_rst_blink");
    wait_until(r + 9);

    // Bounded drain of anything still queued.
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    check("sb_drain", sb_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
